// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM data-memory controller.
package sram_ctrl_pkg;

  localparam int SRAM_DW         = 16;
  localparam int SRAM_AW_DEFAULT = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/sram_ctrl.sv
// Splits each 32-bit load/store into two halfword SRAM phases (low half first);
// ready stays low from request until the DONE cycle, freezing the pipeline.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = SRAM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t      r_state;
  op_t         r_op;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_read_data;
  logic        w_phase_end;
  logic        w_unused_addr;

  assign w_phase_end   = (r_cnt == CNT_LAST);
  // Byte-lane bits and bits above the SRAM window never reach the pads.
  assign w_unused_addr = ^{address[31:SRAM_AW+1], address[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= OP_RD;
      r_cnt       <= '0;
      r_read_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (wr_en || rd_en) begin
            r_op    <= wr_en ? OP_WR : OP_RD;
            r_state <= LO;
          end
        end
        LO: begin
          if (w_phase_end) begin
            if (r_op == OP_RD) r_read_data[15:0] <= sram_dq_in;
            r_cnt   <= '0;
            r_state <= HI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HI: begin
          if (w_phase_end) begin
            if (r_op == OP_RD) r_read_data[31:16] <= sram_dq_in;
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign read_data = r_read_data;
  assign ready     = ((r_state == IDLE) && !rd_en && !wr_en) || (r_state == DONE);

  // Pad controls depend only on registered state/op, so they are glitch-free per phase.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_ce_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    if ((r_state == LO) || (r_state == HI)) begin
      sram_addr = {address[SRAM_AW:2], (r_state == HI)};
      sram_ce_n = 1'b0;
      sram_ub_n = 1'b0;
      sram_lb_n = 1'b0;
      if (r_op == OP_WR) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (r_state == HI) ? write_data[31:16] : write_data[15:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

endmodule
